axi_lite_ic_1xn: RTL

Parametrised AXI4-Lite interconnect routing one master to NUM_SLAVES slaves by per-slave base/mask address decode. It sits between the CPU data port and the peripheral/memory slaves and generalises the 1x2 crossbar to N slaves. It returns proper BRESP/RRESP codes: DECERR for unmapped addresses and, optionally, SLVERR on a slave response timeout. One write and one read transaction may be in flight concurrently, at most one of each.

---
 rtl/axi_lite_ic_1xn_if.sv | 37 +++
 rtl/axi_lite_ic_1xn.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ic_1xn_if.sv
// AXI4-Lite bundle, N lanes of handshake signals with a shared address/data path.
// N=1 for the master side, N=NUM_SLAVES for the slave fan-out.
interface axi_lite_ic_1xn_if #(
    parameter int N = 1
);
    logic [N-1:0]    awvalid;
    logic [N-1:0]    awready;
    logic [31:0]     awaddr;
    logic [2:0]      awprot;
    logic [N-1:0]    wvalid;
    logic [N-1:0]    wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic [N-1:0]    bvalid;
    logic [N-1:0]    bready;
    logic [2*N-1:0]  bresp;
    logic [N-1:0]    arvalid;
    logic [N-1:0]    arready;
    logic [31:0]     araddr;
    logic [2:0]      arprot;
    logic [N-1:0]    rvalid;
    logic [N-1:0]    rready;
    logic [32*N-1:0] rdata;
    logic [2*N-1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_ic_1xn.sv
// AXI4-Lite 1-master to N-slave interconnect with base/mask decode and DECERR.
// Optional response watchdog (SLVERR) enabled by defining AXI_IC_TIMEOUT_EN.
module axi_lite_ic_1xn #(
    parameter int                         NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]   SLV_BASE       = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]   SLV_MASK       = {NUM_SLAVES{32'hFFFF_0000}},
    parameter logic [31:0]                OOB_RDATA      = 32'hDEAD_BEEF,
    parameter int                         TIMEOUT_CYCLES = 256
) (
    input logic              clk,
    input logic              rst,
    axi_lite_ic_1xn_if.slave m,
    axi_lite_ic_1xn_if.master s
);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_st_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_st_e;

    // Returns {oob, sel}; lowest matching index wins.
    function automatic logic [SW:0] decode(input logic [31:0] a);
        logic [SW:0] r;
        r = {1'b1, SW'(0)};
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((a & SLV_MASK[32*i +: 32]) ==
                (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))
                r = {1'b0, SW'(i)};
        end
        return r;
    endfunction

    wr_st_e                wst_q, wst_d;
    rd_st_e                rst_q, rst_d;
    logic [SW-1:0]         wsel_q, wsel_d, rsel_q, rsel_d;
    logic                  woob_q, woob_d, roob_q, roob_d;
    logic [SW-1:0]         aw_sel, ar_sel;
    logic                  aw_oob, ar_oob;
    logic                  wto, rto;

    logic [NUM_SLAVES-1:0] aw_v, w_v, b_rdy, ar_v, r_rdy;
    logic                  aw_rdy, w_rdy, b_v, ar_rdy, r_v;
    logic [1:0]            b_resp, r_resp;
    logic [31:0]           r_data;

    assign {aw_oob, aw_sel} = decode(m.awaddr);
    assign {ar_oob, ar_sel} = decode(m.araddr);

    assign s.awaddr  = m.awaddr;
    assign s.awprot  = m.awprot;
    assign s.wdata   = m.wdata;
    assign s.wstrb   = m.wstrb;
    assign s.araddr  = m.araddr;
    assign s.arprot  = m.arprot;

    assign s.awvalid = aw_v;
    assign s.wvalid  = w_v;
    assign s.bready  = b_rdy;
    assign s.arvalid = ar_v;
    assign s.rready  = r_rdy;
    assign m.awready = aw_rdy;
    assign m.wready  = w_rdy;
    assign m.bvalid  = b_v;
    assign m.bresp   = b_resp;
    assign m.arready = ar_rdy;
    assign m.rvalid  = r_v;
    assign m.rdata   = r_data;
    assign m.rresp   = r_resp;

`ifdef AXI_IC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

    assign wto = (wcnt_q == CW'(TIMEOUT_CYCLES));
    assign rto = (rcnt_q == CW'(TIMEOUT_CYCLES));

    // Watchdogs: zero outside RESP, count while the slave response is pending.
    always_comb begin
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        if (wst_q != WR_RESP)
            wcnt_d = '0;
        else if (!woob_q && !wto && !s.bvalid[wsel_q])
            wcnt_d = wcnt_q + 1'b1;
        if (rst_q != RD_RESP)
            rcnt_d = '0;
        else if (!roob_q && !rto && !s.rvalid[rsel_q])
            rcnt_d = rcnt_q + 1'b1;
    end

    // Watchdog counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end
`else
    // Watchdog disabled: a response is awaited indefinitely.
    assign wto = (TIMEOUT_CYCLES < 0);
    assign rto = (TIMEOUT_CYCLES < 0);
`endif

    // Write FSM: AW routing, then W, then B from the latched slave or locally.
    always_comb begin
        wst_d  = wst_q;
        wsel_d = wsel_q;
        woob_d = woob_q;
        aw_v   = '0;
        aw_rdy = 1'b0;
        w_v    = '0;
        w_rdy  = 1'b0;
        b_rdy  = '0;
        b_v    = 1'b0;
        b_resp = 2'b00;
        unique case (wst_q)
            WR_IDLE: begin
                aw_rdy = aw_oob ? 1'b1 : s.awready[aw_sel];
                if (!aw_oob) aw_v[aw_sel] = m.awvalid[0];
                if (m.awvalid[0] && aw_rdy) begin
                    wst_d  = WR_DATA;
                    wsel_d = aw_sel;
                    woob_d = aw_oob;
                end
            end
            WR_DATA: begin
                w_rdy = woob_q ? 1'b1 : s.wready[wsel_q];
                if (!woob_q) w_v[wsel_q] = m.wvalid[0];
                if (m.wvalid[0] && w_rdy) wst_d = WR_RESP;
            end
            WR_RESP: begin
                if (woob_q) begin
                    b_v    = 1'b1;
                    b_resp = 2'b11;
                end else if (wto) begin
                    b_v    = 1'b1;
                    b_resp = 2'b10;
                end else begin
                    b_v           = s.bvalid[wsel_q];
                    b_resp        = s.bresp[2*int'(wsel_q) +: 2];
                    b_rdy[wsel_q] = m.bready[0];
                end
                if (b_v && m.bready[0]) wst_d = WR_IDLE;
            end
            default: wst_d = WR_IDLE;
        endcase
        if (rst) begin
            aw_v   = '0;
            aw_rdy = 1'b0;
            w_v    = '0;
            w_rdy  = 1'b0;
            b_rdy  = '0;
            b_v    = 1'b0;
            b_resp = 2'b00;
        end
    end

    // Read FSM: AR routing, then R from the latched slave or locally.
    always_comb begin
        rst_d  = rst_q;
        rsel_d = rsel_q;
        roob_d = roob_q;
        ar_v   = '0;
        ar_rdy = 1'b0;
        r_rdy  = '0;
        r_v    = 1'b0;
        r_data = '0;
        r_resp = 2'b00;
        unique case (rst_q)
            RD_IDLE: begin
                ar_rdy = ar_oob ? 1'b1 : s.arready[ar_sel];
                if (!ar_oob) ar_v[ar_sel] = m.arvalid[0];
                if (m.arvalid[0] && ar_rdy) begin
                    rst_d  = RD_RESP;
                    rsel_d = ar_sel;
                    roob_d = ar_oob;
                end
            end
            RD_RESP: begin
                if (roob_q) begin
                    r_v    = 1'b1;
                    r_data = OOB_RDATA;
                    r_resp = 2'b11;
                end else if (rto) begin
                    r_v    = 1'b1;
                    r_data = OOB_RDATA;
                    r_resp = 2'b10;
                end else begin
                    r_v           = s.rvalid[rsel_q];
                    r_data        = s.rdata[32*int'(rsel_q) +: 32];
                    r_resp        = s.rresp[2*int'(rsel_q) +: 2];
                    r_rdy[rsel_q] = m.rready[0];
                end
                if (r_v && m.rready[0]) rst_d = RD_IDLE;
            end
            default: rst_d = RD_IDLE;
        endcase
        if (rst) begin
            ar_v   = '0;
            ar_rdy = 1'b0;
            r_rdy  = '0;
            r_v    = 1'b0;
            r_data = '0;
            r_resp = 2'b00;
        end
    end

    // State and latched routing registers for both FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wst_q  <= WR_IDLE;
            wsel_q <= '0;
            woob_q <= 1'b0;
            rst_q  <= RD_IDLE;
            rsel_q <= '0;
            roob_q <= 1'b0;
        end else begin
            wst_q  <= wst_d;
            wsel_q <= wsel_d;
            woob_q <= woob_d;
            rst_q  <= rst_d;
            rsel_q <= rsel_d;
            roob_q <= roob_d;
        end
    end
endmodule
